// File: rtl/dino_pkg.sv
// Shared constants for the runner game: FSM state encoding and the default
// obstacle geometry/speed values used by the scheduler, renderer and
// collision logic.
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } game_state_t;

    localparam int DINO_SPAWN_X    = 640;
    localparam int DINO_RESTART_X  = 630;
    localparam int DINO_RETIRE_X   = -40;
    localparam int DINO_MIN_GAP    = 250;
    localparam int DINO_BASE_SPEED = 4;

endpackage

// File: rtl/obstacle_slot.sv
// obstacle_slot: one obstacle's registers (signed x, sprite type, active).
// Ports:
//   pclk, rst_n          clock, synchronous active-low reset
//   rearm                return to the reset values (game restart)
//   load, load_x,
//   load_type            spawn: take new x/type and become active
//   move, step           x <= x - step (13-bit wrap)
//   retire               clear active
//   x, typ, active       registered slot state
module obstacle_slot #(
    parameter int   RST_X      = 0,
    parameter logic RST_ACTIVE = 1'b0
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               rearm,
    input  logic               load,
    input  logic               retire,
    input  logic               move,
    input  logic [6:0]         step,
    input  logic signed [12:0] load_x,
    input  logic [1:0]         load_type,
    output logic signed [12:0] x,
    output logic [1:0]         typ,
    output logic               active
);

    always_ff @(posedge pclk) begin
        if (!rst_n || rearm) begin
            x      <= 13'(RST_X);
            typ    <= '0;
            active <= RST_ACTIVE;
        end else if (load) begin
            x      <= load_x;
            typ    <= load_type;
            active <= 1'b1;
        end else begin
            if (move)
                x <= x - $signed({6'b0, step});
            if (retire)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: spawns, scrolls and retires up to NUM_SLOTS obstacles
// per video frame, keeps the score and derives the scroll speed.
// Ports:
//   pclk, rst_n    clock, synchronous active-low reset
//   frame_tick     one-cycle pulse per frame (motion step)
//   start          IDLE->RUN, HALT->IDLE (re-arm)
//   collision      level; RUN->HALT, wins over frame_tick
//   rnd            LFSR value: rnd[9:8] sprite type, rnd[8:0] next gap offset
//   slot_x         signed 13-bit x per slot, slot i at [13i+12:13i]
//   slot_type      2-bit type per slot
//   slot_active    per-slot valid
//   score          retired obstacle count, saturating at 1023
//   speed          scroll step in pixels per frame
//   spawn_pulse    one cycle after a spawn
//   state_o        IDLE=0, RUN=1, HALT=2
// Build option: define OBSTACLE_SPEEDUP_EN to make speed follow score[9:4];
// otherwise speed stays at BASE_SPEED.
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int NUM_SLOTS  = 3,
    parameter int SPAWN_X    = DINO_SPAWN_X,
    parameter int RESTART_X  = DINO_RESTART_X,
    parameter int RETIRE_X   = DINO_RETIRE_X,
    parameter int MIN_GAP    = DINO_MIN_GAP,
    parameter int BASE_SPEED = DINO_BASE_SPEED
) (
    input  logic                      pclk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      start,
    input  logic                      collision,
    input  logic [9:0]                rnd,
    output logic [13*NUM_SLOTS-1:0]   slot_x,
    output logic [2*NUM_SLOTS-1:0]    slot_type,
    output logic [NUM_SLOTS-1:0]      slot_active,
    output logic [9:0]                score,
    output logic [6:0]                speed,
    output logic                      spawn_pulse,
    output logic [1:0]                state_o
);

    localparam logic signed [12:0] RETIRE_X13 = 13'(RETIRE_X);

    game_state_t        state;
    logic [1:0]         last;
    logic [8:0]         gap_off;

    logic signed [12:0] xs [NUM_SLOTS];
    logic [1:0]         ts [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] act, mv, ret, ld;

    logic               tick_run, rearm, spawn_ok;
    logic [1:0]         nxt, nret;
    logic signed [12:0] spawn_thr;
    logic [10:0]        score_sum;
    logic [9:0]         score_next;
    logic [6:0]         speed_next;

    // Collision takes priority over the frame tick in RUN.
    assign tick_run  = (state == ST_RUN) && frame_tick && !collision;
    assign rearm     = (state == ST_HALT) && start;
    assign nxt       = (last == 2'(NUM_SLOTS - 1)) ? 2'd0 : last + 2'd1;
    assign spawn_thr = 13'(SPAWN_X - MIN_GAP) - 13'(gap_off);

    // All decisions use pre-update slot state; a still-active next slot
    // defers the spawn until a later tick instead of skipping ahead.
    assign spawn_ok  = tick_run && !act[nxt] &&
                       (!act[last] || (xs[last] < spawn_thr));

    always_comb begin
        mv   = '0;
        ret  = '0;
        ld   = '0;
        nret = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            mv[i]  = tick_run && act[i];
            ret[i] = mv[i] && (xs[i] < RETIRE_X13);
            ld[i]  = spawn_ok && (nxt == 2'(i));
            nret   = nret + 2'(ret[i]);
        end
    end

    assign score_sum  = {1'b0, score} + {9'b0, nret};
    assign score_next = score_sum[10] ? 10'd1023 : score_sum[9:0];

`ifdef OBSTACLE_SPEEDUP_EN
    assign speed_next = 7'(BASE_SPEED) + {1'b0, score_next[9:4]};
`else
    assign speed_next = 7'(BASE_SPEED);
`endif

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        obstacle_slot #(
            .RST_X      ((g == 0) ? RESTART_X : 0),
            .RST_ACTIVE ((g == 0) ? 1'b1 : 1'b0)
        ) u_slot (
            .pclk      (pclk),
            .rst_n     (rst_n),
            .rearm     (rearm),
            .load      (ld[g]),
            .retire    (ret[g]),
            .move      (mv[g]),
            .step      (speed),
            .load_x    (13'(SPAWN_X)),
            .load_type (rnd[9:8]),
            .x         (xs[g]),
            .typ       (ts[g]),
            .active    (act[g])
        );
        assign slot_x[13*g +: 13]  = xs[g];
        assign slot_type[2*g +: 2] = ts[g];
    end

    assign slot_active = act;
    assign state_o     = state;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last        <= '0;
            gap_off     <= '0;
            score       <= '0;
            speed       <= 7'(BASE_SPEED);
            spawn_pulse <= 1'b0;
        end else begin
            spawn_pulse <= spawn_ok;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        gap_off <= rnd[8:0];
                    end
                end
                ST_RUN: begin
                    if (collision) begin
                        state <= ST_HALT;
                    end else if (frame_tick) begin
                        score <= score_next;
                        speed <= speed_next;
                        if (spawn_ok) begin
                            last    <= nxt;
                            gap_off <= rnd[8:0];
                        end
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state   <= ST_IDLE;
                        last    <= '0;
                        gap_off <= '0;
                        score   <= '0;
                        speed   <= 7'(BASE_SPEED);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
